// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: walks an active-low column strobe, debounces
// presses and releases on the synchronized rows, and reports the key code.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] shift_col,
  output logic [3:0] key_value,
  output logic       key_valid,
  output logic       key_down
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DB_LAST  = 4'(DEBOUNCE_CNT);

  state_t      state;
  logic [3:0]  row_meta;
  logic [3:0]  row_sync;
  logic [15:0] div_cnt;
  logic [1:0]  col;
  logic [1:0]  cand_row;
  logic [3:0]  match_cnt;
  logic [3:0]  rel_cnt;
  logic        sample;
  logic        single_low;
  logic [1:0]  row_idx;

  function automatic logic [3:0] col_drive(input logic [1:0] c);
    return ~(4'b0001 << c);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_meta <= 4'b1111;
      row_sync <= 4'b1111;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // Dwell counter free-runs in every state; its last count is the sample point.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      div_cnt <= '0;
    else if (div_cnt == DIV_LAST)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 16'd1;
  end

  assign sample = (div_cnt == DIV_LAST);

  // Only a pattern with exactly one low row bit identifies a key.
  always_comb begin
    single_low = 1'b1;
    row_idx    = 2'd0;
    case (row_sync)
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: single_low = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      col       <= 2'd0;
      shift_col <= 4'b1110;
      cand_row  <= 2'd0;
      match_cnt <= '0;
      rel_cnt   <= '0;
      key_value <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (sample) begin
        case (state)
          SCAN: begin
            if (single_low) begin
              cand_row  <= row_idx;
              match_cnt <= 4'd1;
              if (DEBOUNCE_CNT == 1) begin
                key_value <= {col, row_idx};
                key_valid <= 1'b1;
                key_down  <= 1'b1;
                state     <= HELD;
              end else begin
                state <= DEBOUNCE;
              end
            end else begin
              col       <= col + 2'd1;
              shift_col <= col_drive(col + 2'd1);
            end
          end
          DEBOUNCE: begin
            if (single_low && row_idx == cand_row) begin
              if (match_cnt + 4'd1 == DB_LAST) begin
                key_value <= {col, cand_row};
                key_valid <= 1'b1;
                key_down  <= 1'b1;
                state     <= HELD;
              end else begin
                match_cnt <= match_cnt + 4'd1;
              end
            end else begin
              state     <= SCAN;
              col       <= col + 2'd1;
              shift_col <= col_drive(col + 2'd1);
            end
          end
          HELD: begin
            if (row_sync == 4'b1111) begin
              rel_cnt <= 4'd1;
              if (DEBOUNCE_CNT == 1) begin
                key_down  <= 1'b0;
                state     <= SCAN;
                col       <= col + 2'd1;
                shift_col <= col_drive(col + 2'd1);
              end else begin
                state <= RELEASE;
              end
            end
          end
          RELEASE: begin
            if (row_sync == 4'b1111) begin
              if (rel_cnt + 4'd1 == DB_LAST) begin
                key_down  <= 1'b0;
                state     <= SCAN;
                col       <= col + 2'd1;
                shift_col <= col_drive(col + 2'd1);
              end else begin
                rel_cnt <= rel_cnt + 4'd1;
              end
            end else begin
              state <= HELD;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl (SCAN_DIV=4, DEBOUNCE_CNT=3) with a
// simple keypad model that pulls a row low while its column is strobed.
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row;
  logic [3:0] shift_col;
  logic [3:0] key_value;
  logic       key_valid;
  logic       key_down;

  logic       press_en  = 1'b0;
  logic [1:0] press_col = 2'd0;
  logic [3:0] press_rows = 4'b0000;
  logic       use_force = 1'b0;
  logic [3:0] row_force = 4'b1111;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;

  keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .shift_col (shift_col),
    .key_value (key_value),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  always #5 clk = ~clk;

  assign row = use_force ? row_force :
               ((press_en && !shift_col[press_col]) ? ~press_rows : 4'b1111);

  always @(negedge clk) if (key_valid) pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] seq [5];
    seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    // Reset state
    reset = 1'b1;
    step(3);
    chk("rst_shift_col", shift_col, 4'b1110);
    chk("rst_key_value", key_value, 4'd0);
    chk("rst_key_valid", key_valid, 1'b0);
    chk("rst_key_down",  key_down,  1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Idle scan: column changes every 4 clocks
    for (int k = 0; k < 4; k++) begin
      step(3);
      chk("idle_hold", shift_col, seq[k]);
      step(1);
      chk("idle_next", shift_col, seq[k+1]);
    end
    chk("idle_no_valid", pulses, 0);

    // Press col2/row1: accepted on the 3rd matching sample at column 2
    press_col = 2'd2; press_rows = 4'b0010; press_en = 1'b1;
    step(19);
    chk("press_pre_valid", key_valid, 1'b0);
    chk("press_pre_down",  key_down,  1'b0);
    step(1);
    chk("press_valid", key_valid, 1'b1);
    chk("press_value", key_value, 4'd9);
    chk("press_down",  key_down,  1'b1);
    chk("press_col",   shift_col, 4'b1011);
    step(1);
    chk("press_pulse_end", key_valid, 1'b0);
    step(3);
    chk("held_col",  shift_col, 4'b1011);
    chk("held_down", key_down,  1'b1);

    // Release: key_down clears on 3rd idle sample, scan resumes at column 3
    press_en = 1'b0;
    step(11);
    chk("rel_pre_down", key_down,  1'b1);
    chk("rel_pre_col",  shift_col, 4'b1011);
    step(1);
    chk("rel_down", key_down,  1'b0);
    chk("rel_col",  shift_col, 4'b0111);
    chk("rel_pulses", pulses, 1);

    // Bounce: one low sample at column 0, then the column advances
    step(4);
    chk("bounce_start_col", shift_col, 4'b1110);
    row_force = 4'b1110; use_force = 1'b1;
    step(4);
    chk("bounce_frozen", shift_col, 4'b1110);
    row_force = 4'b1111;
    step(4);
    chk("bounce_advance", shift_col, 4'b1101);
    chk("bounce_no_valid", pulses, 1);

    // Multi-key pattern never qualifies
    row_force = 4'b1100;
    step(4);
    chk("multi_col2", shift_col, 4'b1011);
    step(4);
    chk("multi_col3", shift_col, 4'b0111);
    step(4);
    chk("multi_col0", shift_col, 4'b1110);
    chk("multi_no_valid", pulses, 1);
    use_force = 1'b0;

    // Codes: col3/row3 then col0/row0
    press_col = 2'd3; press_rows = 4'b1000; press_en = 1'b1;
    step(24);
    chk("code15_valid", key_valid, 1'b1);
    chk("code15_value", key_value, 4'd15);
    step(1);
    chk("code15_pulse_end", key_valid, 1'b0);
    step(3);
    press_en = 1'b0;
    step(12);
    chk("code15_released", key_down,  1'b0);
    chk("code15_rel_col",  shift_col, 4'b1110);
    chk("code15_hold_value", key_value, 4'd15);
    press_col = 2'd0; press_rows = 4'b0001; press_en = 1'b1;
    step(11);
    chk("code0_pre_valid", key_valid, 1'b0);
    step(1);
    chk("code0_valid", key_valid, 1'b1);
    chk("code0_value", key_value, 4'd0);
    step(1);
    chk("code0_down", key_down, 1'b1);
    chk("code_pulses", pulses, 3);

    // Reset mid-HELD acts without a clock edge
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_down",  key_down,  1'b0);
    chk("mid_rst_col",   shift_col, 4'b1110);
    chk("mid_rst_valid", key_valid, 1'b0);
    press_en = 1'b0;
    step(2);
    @(negedge clk);
    reset = 1'b0;
    step(3);
    chk("post_rst_col0", shift_col, 4'b1110);
    step(1);
    chk("post_rst_col1", shift_col, 4'b1101);
    chk("final_pulses", pulses, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
